// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_add_pkg;

  localparam int SA_DEF_N = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/serial_add_dp.sv
// Bit-serial adder datapath: two right-shift registers, one full adder and
// an enabled carry flop. ld has priority over sh.
module serial_add_dp
  import serial_add_pkg::*;
#(
  parameter int N = SA_DEF_N
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         ld,
  input  logic         sh,
  input  logic         cinit,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N-1:0] rega_q, rega_d;
  logic [N-1:0] regb_q, regb_d;
  logic         carry_q, carry_d;
  logic         s;

  always_comb begin
    rega_d  = rega_q;
    regb_d  = regb_q;
    carry_d = carry_q;
    s       = rega_q[0] ^ regb_q[0] ^ carry_q;
    if (ld) begin
      rega_d  = a;
      regb_d  = b;
      carry_d = cinit;
    end else if (sh) begin
      // sum bits enter at the top of A so A holds the result after N shifts
      rega_d  = {s, rega_q[N-1:1]};
      regb_d  = {1'b0, regb_q[N-1:1]};
      carry_d = maj3(rega_q[0], regb_q[0], carry_q);
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rega_q  <= '0;
      regb_q  <= '0;
      carry_q <= 1'b0;
    end else begin
      rega_q  <= rega_d;
      regb_q  <= regb_d;
      carry_q <= carry_d;
    end
  end

  assign sum  = rega_q;
  assign cout = carry_q;

endmodule

// File: rtl/serial_add_seq.sv
// Self-sequencing bit-serial adder with valid/ready operand and result ports.
// Define SERADD_SUB_EN to add the op input (1 = subtract a - b).
//
// state | meaning
// IDLE  | waiting for an operand pair, start_ready high
// SHIFT | N shift cycles through the full adder
// DONE  | result presented, waiting for res_ready
module serial_add_seq
  import serial_add_pkg::*;
#(
  parameter  int N  = SA_DEF_N,
  localparam int CW = $clog2(N)
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
`ifdef SERADD_SUB_EN
  input  logic         op,
`endif
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         busy
);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ld, sh, cinit;
  logic [N-1:0]  b_ld;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ld      = 1'b0;
    sh      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          ld      = 1'b1;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sh    = 1'b1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) state_d = DONE;
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Subtraction is a + ~b + 1: invert B on load and seed the carry.
  always_comb begin
    b_ld  = b;
    cinit = 1'b0;
`ifdef SERADD_SUB_EN
    if (op) begin
      b_ld  = ~b;
      cinit = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  serial_add_dp #(.N(N)) u_dp (
    .clk   (clk),
    .clr   (clr),
    .ld    (ld),
    .sh    (sh),
    .cinit (cinit),
    .a     (a),
    .b     (b_ld),
    .sum   (sum),
    .cout  (cout)
  );

  assign start_ready = (state_q == IDLE);
  assign res_valid   = (state_q == DONE);
  assign busy        = (state_q == SHIFT) || (state_q == DONE);

endmodule

// File: tb/tb_serial_add_seq.sv
// Directed bench for serial_add_seq (N=4): vector table plus corner sequences.
module tb_serial_add_seq;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         clr = 1'b1;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         op = 1'b0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [N-1:0] sum;
  logic         cout;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         op;
    logic [N-1:0] s;
    logic         c;
  } vec_t;

  vec_t vecs[$];

  serial_add_seq #(.N(N)) dut (
    .clk         (clk),
    .clr         (clr),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
`ifdef SERADD_SUB_EN
    .op          (op),
`endif
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .sum         (sum),
    .cout        (cout),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_res(output int lat);
    lat = 0;
    while (!res_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with it idle.
  task automatic run_op(input logic [N-1:0] va, input logic [N-1:0] vb,
                        input logic vop, input logic [N-1:0] es,
                        input logic ec, input string tag);
    int lat;
    chk({tag, " start_ready"}, int'(start_ready), 1);
    a = va; b = vb; op = vop;
    start_valid = 1'b1;
    res_ready   = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    a = ~va; b = ~vb; op = ~vop;
    chk({tag, " busy"}, int'(busy), 1);
    chk({tag, " start_ready_low"}, int'(start_ready), 0);
    wait_res(lat);
    chk({tag, " latency"}, lat, N);
    chk({tag, " sum"}, int'(sum), int'(es));
    chk({tag, " cout"}, int'(cout), int'(ec));
    @(negedge clk);
    chk({tag, " res_valid_drop"}, int'(res_valid), 0);
    chk({tag, " start_ready_back"}, int'(start_ready), 1);
  endtask

  initial begin
    int lat;
    int prev_acc;
    int tmo;
    logic [N-1:0] bb_a [4];
    logic [N-1:0] bb_b [4];

    vecs.push_back('{4'd5,  4'd3,  1'b0, 4'd8,  1'b0});
    vecs.push_back('{4'd15, 4'd1,  1'b0, 4'd0,  1'b1});
    vecs.push_back('{4'd2,  4'd2,  1'b0, 4'd4,  1'b0});
    vecs.push_back('{4'd9,  4'd9,  1'b0, 4'd2,  1'b1});
    vecs.push_back('{4'd7,  4'd9,  1'b0, 4'd0,  1'b1});
    vecs.push_back('{4'd0,  4'd0,  1'b0, 4'd0,  1'b0});
    vecs.push_back('{4'd10, 4'd11, 1'b0, 4'd5,  1'b1});
    vecs.push_back('{4'd12, 4'd3,  1'b0, 4'd15, 1'b0});
`ifdef SERADD_SUB_EN
    vecs.push_back('{4'd5,  4'd3,  1'b1, 4'd2,  1'b1});
    vecs.push_back('{4'd3,  4'd5,  1'b1, 4'd14, 1'b0});
    vecs.push_back('{4'd3,  4'd5,  1'b0, 4'd8,  1'b0});
    vecs.push_back('{4'd7,  4'd7,  1'b1, 4'd0,  1'b1});
`endif

    // reset state
    repeat (3) @(negedge clk);
    chk("rst sum", int'(sum), 0);
    chk("rst cout", int'(cout), 0);
    chk("rst res_valid", int'(res_valid), 0);
    chk("rst busy", int'(busy), 0);
    clr = 1'b0;
    @(negedge clk);
    chk("rst start_ready", int'(start_ready), 1);

    foreach (vecs[i])
      run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].s, vecs[i].c,
             $sformatf("vec%0d", i));

    // stall in DONE; start_valid there must be ignored
    a = 4'd6; b = 4'd7; op = 1'b0;
    start_valid = 1'b1;
    res_ready   = 1'b0;
    @(negedge clk);
    start_valid = 1'b0;
    wait_res(lat);
    chk("stall latency", lat, N);
    for (int i = 0; i < 3; i++) begin
      chk("stall res_valid", int'(res_valid), 1);
      chk("stall sum", int'(sum), 13);
      chk("stall cout", int'(cout), 0);
      chk("stall start_ready", int'(start_ready), 0);
      start_valid = (i == 1);
      a = 4'd1; b = 4'd1;
      @(negedge clk);
    end
    start_valid = 1'b0;
    chk("stall held sum", int'(sum), 13);
    res_ready = 1'b1;
    @(negedge clk);
    chk("stall taken res_valid", int'(res_valid), 0);
    chk("stall kept sum", int'(sum), 13);
    chk("stall start_ready", int'(start_ready), 1);
    @(negedge clk);
    chk("stall not queued busy", int'(busy), 0);

    // clr mid-SHIFT
    a = 4'd9; b = 4'd9;
    start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (2) @(negedge clk);
    clr = 1'b1;
    #1;
    chk("abort sum", int'(sum), 0);
    chk("abort cout", int'(cout), 0);
    chk("abort res_valid", int'(res_valid), 0);
    chk("abort busy", int'(busy), 0);
    @(negedge clk);
    clr = 1'b0;
    chk("abort start_ready", int'(start_ready), 1);
    run_op(4'd9, 4'd9, 1'b0, 4'd2, 1'b1, "reissue");

    // back-to-back with start_valid held high
    bb_a[0] = 4'd1;  bb_b[0] = 4'd2;
    bb_a[1] = 4'd8;  bb_b[1] = 4'd8;
    bb_a[2] = 4'd14; bb_b[2] = 4'd3;
    bb_a[3] = 4'd4;  bb_b[3] = 4'd11;
    prev_acc = 0;
    res_ready = 1'b1;
    a = bb_a[0]; b = bb_b[0];
    start_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tmo = 0;
      while (!start_ready && tmo < 20) begin
        @(negedge clk);
        tmo++;
      end
      chk("b2b ready timeout", int'(tmo < 20), 1);
      if (k > 0) chk("b2b spacing", cyc - prev_acc, N + 2);
      prev_acc = cyc;
      @(negedge clk);
      if (k < 3) begin
        a = bb_a[k+1]; b = bb_b[k+1];
      end else begin
        start_valid = 1'b0;
      end
      wait_res(lat);
      chk("b2b latency", lat, N);
      chk($sformatf("b2b%0d sum", k), int'(sum), int'((bb_a[k] + bb_b[k]) & 4'hF));
      chk($sformatf("b2b%0d cout", k), int'(cout), int'(({1'b0, bb_a[k]} + {1'b0, bb_b[k]}) >> 4));
    end
    @(negedge clk);
    @(negedge clk);
    chk("b2b idle", int'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
